// File: rtl/prompt_sequencer.sv
// Frame-synchronous scheduler for the prompt sprite overlays: shows prompts
// 0..N_PROMPTS-1 one at a time, separated by blank gaps, switching only at end-of-frame.
module prompt_sequencer #(
    parameter int N_PROMPTS    = 4,
    parameter int SHOW_FRAMES  = 120,
    parameter int GAP_FRAMES   = 30,
    parameter int BLINK_FRAMES = 0,
    parameter int H_LAST       = 799,
    parameter int V_LAST       = 524,
    localparam int IDX_W       = (N_PROMPTS > 1) ? $clog2(N_PROMPTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           hCount,
    input  logic [9:0]           vCount,
    input  logic                 start,
    input  logic                 skip,
    output logic [N_PROMPTS-1:0] en_out,
    output logic [IDX_W-1:0]     prompt_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 frame_tick,
    output logic [2:0]           o_dbg_state
);

    localparam int SHOW_W = $clog2(SHOW_FRAMES) + 1;
    localparam int GAP_W  = $clog2(GAP_FRAMES) + 1;
    localparam int CNT_W  = (SHOW_W > GAP_W) ? SHOW_W : GAP_W;
    localparam int BLK_W  = $clog2(BLINK_FRAMES + 1) + 1;

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_FRAMES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_FRAMES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_PROMPTS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_SHOW = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Control protocol: start is a level sampled only in IDLE, skip is a level
    // sampled only in SHOW (latched until the next frame tick), done is a
    // single-cycle pulse; there is no back-pressure on any of them.

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic [BLK_W-1:0]     r_bcnt;
    logic                 r_phase;
    logic                 r_skip_pend;
    logic                 r_eof_q;
    logic                 r_frame_tick;
    logic [N_PROMPTS-1:0] r_en;

    state_t               w_state_nx;
    logic [IDX_W-1:0]     w_idx_nx;
    logic [CNT_W-1:0]     w_cnt_nx;
    logic [BLK_W-1:0]     w_bcnt_nx;
    logic                 w_phase_nx;
    logic                 w_skip_pend_nx;
    logic [N_PROMPTS-1:0] w_en_nx;
    logic                 w_eof;
    logic                 w_tick;

    // The counters may hold the last pixel for several clocks; only the first counts.
    assign w_eof  = (hCount == 10'(H_LAST)) && (vCount == 10'(V_LAST));
    assign w_tick = w_eof & ~r_eof_q;

    always_comb begin
        w_state_nx     = r_state;
        w_idx_nx       = r_idx;
        w_cnt_nx       = r_cnt;
        w_bcnt_nx      = r_bcnt;
        w_phase_nx     = r_phase;
        w_skip_pend_nx = 1'b0;
        w_en_nx        = '0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_ARM;
                    w_idx_nx   = '0;
                end
            end
            S_ARM: begin
                if (w_tick) begin
                    w_state_nx = S_SHOW;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                    w_bcnt_nx  = '0;
                    w_phase_nx = 1'b0;
                end
            end
            S_SHOW: begin
                if (w_tick) begin
                    if (r_skip_pend || skip || (r_cnt == SHOW_LAST)) begin
                        w_state_nx = S_GAP;
                        w_cnt_nx   = '0;
                        w_bcnt_nx  = '0;
                        w_phase_nx = 1'b0;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                        if (BLINK_FRAMES > 0) begin
                            if (r_bcnt == BLK_LAST) begin
                                w_bcnt_nx  = '0;
                                w_phase_nx = ~r_phase;
                            end else begin
                                w_bcnt_nx = r_bcnt + BLK_W'(1);
                            end
                        end
                    end
                end else begin
                    w_skip_pend_nx = r_skip_pend | skip;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    if (r_cnt == GAP_LAST) begin
                        if (r_idx == IDX_LAST) begin
                            w_state_nx = S_DONE;
                        end else begin
                            w_state_nx = S_SHOW;
                            w_idx_nx   = r_idx + IDX_W'(1);
                            w_cnt_nx   = '0;
                            w_bcnt_nx  = '0;
                            w_phase_nx = 1'b0;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Enables are computed from next-state values so they change on the tick edge.
        for (int i = 0; i < N_PROMPTS; i++) begin
            w_en_nx[i] = (w_state_nx == S_SHOW) && !w_phase_nx && (w_idx_nx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_bcnt       <= '0;
            r_phase      <= 1'b0;
            r_skip_pend  <= 1'b0;
            r_eof_q      <= 1'b0;
            r_frame_tick <= 1'b0;
            r_en         <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_idx        <= w_idx_nx;
            r_cnt        <= w_cnt_nx;
            r_bcnt       <= w_bcnt_nx;
            r_phase      <= w_phase_nx;
            r_skip_pend  <= w_skip_pend_nx;
            r_eof_q      <= w_eof;
            r_frame_tick <= w_tick;
            r_en         <= w_en_nx;
        end
    end

    assign en_out      = r_en;
    assign prompt_idx  = r_idx;
    assign busy        = (r_state == S_ARM) || (r_state == S_SHOW) || (r_state == S_GAP);
    assign done        = (r_state == S_DONE);
    assign frame_tick  = r_frame_tick;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prompt_sequencer.sv
// Bench for prompt_sequencer: a steady instance and a blinking instance share one
// synthetic VGA counter stream; expected output events are queued and popped by monitors.
module tb_prompt_sequencer;

    localparam int ACT_NONE    = 0;
    localparam int ACT_START_A = 1;
    localparam int ACT_SKIP_A  = 2;
    localparam int ACT_RST     = 3;
    localparam int ACT_START_B = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic       start_a = 1'b0;
    logic       skip_a = 1'b0;
    logic       start_b = 1'b0;
    logic       skip_b = 1'b0;

    logic [1:0] en_a, en_b;
    logic       idx_a, idx_b;
    logic       busy_a, busy_b, done_a, done_b, ftick_a, ftick_b;
    logic [2:0] dbg_a, dbg_b;

    int checks = 0;
    int errors = 0;
    logic mon_b_en = 1'b1;

    // Each entry is {done, busy, prompt_idx, en_out[1:0]}.
    logic [4:0] exp_q_a[$];
    logic [4:0] exp_q_b[$];

    prompt_sequencer #(
        .N_PROMPTS(2), .SHOW_FRAMES(3), .GAP_FRAMES(1), .BLINK_FRAMES(0),
        .H_LAST(9), .V_LAST(4)
    ) dut_a (
        .clk(clk), .rst(rst), .hCount(hcount), .vCount(vcount),
        .start(start_a), .skip(skip_a), .en_out(en_a), .prompt_idx(idx_a),
        .busy(busy_a), .done(done_a), .frame_tick(ftick_a), .o_dbg_state(dbg_a)
    );

    prompt_sequencer #(
        .N_PROMPTS(2), .SHOW_FRAMES(4), .GAP_FRAMES(1), .BLINK_FRAMES(1),
        .H_LAST(9), .V_LAST(4)
    ) dut_b (
        .clk(clk), .rst(rst), .hCount(hcount), .vCount(vcount),
        .start(start_b), .skip(skip_b), .en_out(en_b), .prompt_idx(idx_b),
        .busy(busy_b), .done(done_b), .frame_tick(ftick_b), .o_dbg_state(dbg_b)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic pa(input logic [4:0] v);
        exp_q_a.push_back(v);
    endtask

    task automatic pb(input logic [4:0] v);
        exp_q_b.push_back(v);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            hcount  = '0;
            vcount  = '0;
            start_a = 1'b0;
            skip_a  = 1'b0;
            start_b = 1'b0;
            rst     = 1'b0;
        end
    endtask

    // One full frame, ppc clocks per pixel; action act is pulsed for one clock at cycle at.
    task automatic fr(input int ppc, input int act, input int at);
        int c;
        c = 0;
        for (int v = 0; v <= 4; v++) begin
            for (int h = 0; h <= 9; h++) begin
                for (int p = 0; p < ppc; p++) begin
                    @(posedge clk); #1;
                    hcount  = 10'(h);
                    vcount  = 10'(v);
                    start_a = (act == ACT_START_A) && (c == at);
                    skip_a  = (act == ACT_SKIP_A) && (c == at);
                    rst     = (act == ACT_RST) && (c == at);
                    start_b = (act == ACT_START_B) && (c == at);
                    c++;
                end
            end
        end
    endtask

    // Full uninterrupted sequence on the steady instance, starting from IDLE.
    task automatic basic_seq(input int ppc);
        pa(5'b0_1_0_00); pa(5'b0_1_0_01); fr(ppc, ACT_START_A, 10 * ppc);
        pa(5'b0_1_0_01); fr(ppc, ACT_NONE, 0);
        pa(5'b0_1_0_01); fr(ppc, ACT_NONE, 0);
        pa(5'b0_1_0_00); fr(ppc, ACT_NONE, 0);
        pa(5'b0_1_1_10); fr(ppc, ACT_NONE, 0);
        pa(5'b0_1_1_10); fr(ppc, ACT_NONE, 0);
        pa(5'b0_1_1_10); fr(ppc, ACT_NONE, 0);
        pa(5'b0_1_1_00); fr(ppc, ACT_NONE, 0);
        pa(5'b1_0_1_00); pa(5'b0_0_1_00); fr(ppc, ACT_NONE, 0);
        pa(5'b0_0_1_00); fr(ppc, ACT_NONE, 0);
    endtask

    // ---------------- scoreboard monitors ----------------
    logic       prev_rst = 1'b1;
    logic [4:0] prev_o_a = '0;
    logic [4:0] prev_o_b = '0;

    always @(negedge clk) prev_rst <= rst;

    task automatic compare(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {done,busy,idx,en}=%b expected %b at %0t", name, got, exp, $time);
        end
        checks++;
        if ($countones(got[1:0]) > 1) begin
            errors++;
            $display("FAIL %s_onehot: got en_out=%b expected at most one bit set", name, got[1:0]);
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] o;
        logic [4:0] e;
        o = {done_a, busy_a, idx_a, en_a};
        if (ftick_a || (o != prev_o_a) || (prev_rst && !rst)) begin
            if (exp_q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_a_unexpected: got event %b expected no event at %0t", o, $time);
            end else begin
                e = exp_q_a.pop_front();
                compare("mon_a", o, e);
            end
        end
        prev_o_a <= o;
    end

    always @(negedge clk) begin
        logic [4:0] o;
        logic [4:0] e;
        o = {done_b, busy_b, idx_b, en_b};
        if (mon_b_en && (ftick_b || (o != prev_o_b) || (prev_rst && !rst))) begin
            if (exp_q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_b_unexpected: got event %b expected no event at %0t", o, $time);
            end else begin
                e = exp_q_b.pop_front();
                compare("mon_b", o, e);
            end
        end
        prev_o_b <= o;
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state of both instances, checked on reset release.
        repeat (4) @(posedge clk);
        pa(5'b0_0_0_00);
        pb(5'b0_0_0_00);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(3);
        mon_b_en = 1'b0;

        // Counters advance every clock.
        basic_seq(1);

        // Slow pixel clock: eof held for 4 clocks, still one tick per frame.
        basic_seq(4);

        // Skip mid-frame in prompt 0's first frame; skip during the gap is ignored.
        pa(5'b0_1_0_00); pa(5'b0_1_0_01); fr(1, ACT_START_A, 10);
        pa(5'b0_1_0_00); fr(1, ACT_SKIP_A, 20);
        pa(5'b0_1_1_10); fr(1, ACT_SKIP_A, 20);
        pa(5'b0_1_1_10); fr(1, ACT_NONE, 0);
        pa(5'b0_1_1_10); fr(1, ACT_NONE, 0);
        pa(5'b0_1_1_00); fr(1, ACT_NONE, 0);
        pa(5'b1_0_1_00); pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);
        pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);

        // Start during SHOW is ignored; skip on the tick cycle acts on that tick.
        pa(5'b0_1_0_00); pa(5'b0_1_0_01); fr(1, ACT_START_A, 10);
        pa(5'b0_1_0_01); fr(1, ACT_START_A, 20);
        pa(5'b0_1_0_01); fr(1, ACT_NONE, 0);
        pa(5'b0_1_0_00); fr(1, ACT_NONE, 0);
        pa(5'b0_1_1_10); fr(1, ACT_NONE, 0);
        pa(5'b0_1_1_00); fr(1, ACT_SKIP_A, 49);
        pa(5'b1_0_1_00); pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);
        pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);

        // Reset in prompt 1 SHOW: outputs clear, no done; then a clean restart.
        pa(5'b0_1_0_00); pa(5'b0_1_0_01); fr(1, ACT_START_A, 10);
        pa(5'b0_1_0_01); fr(1, ACT_NONE, 0);
        pa(5'b0_1_0_01); fr(1, ACT_NONE, 0);
        pa(5'b0_1_0_00); fr(1, ACT_NONE, 0);
        pa(5'b0_1_1_10); fr(1, ACT_NONE, 0);
        pa(5'b0_0_0_00); pa(5'b0_0_0_00); fr(1, ACT_RST, 20);
        pa(5'b0_0_0_00); fr(1, ACT_NONE, 0);
        basic_seq(1);

        // Blinking instance: prompt 0 visible 1,0,1,0 then gap, prompt 1 likewise.
        idle_cycles(3);
        mon_b_en = 1'b1;
        pb(5'b0_1_0_00); pb(5'b0_1_0_01); pa(5'b0_0_1_00); fr(1, ACT_START_B, 10);
        pb(5'b0_1_0_00); pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);
        pb(5'b0_1_0_01); pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);
        pb(5'b0_1_0_00); pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);
        pb(5'b0_1_0_00); pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);
        pb(5'b0_1_1_10); pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);
        pb(5'b0_1_1_00); pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);
        pb(5'b0_1_1_10); pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);
        pb(5'b0_1_1_00); pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);
        pb(5'b0_1_1_00); pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);
        pb(5'b1_0_1_00); pb(5'b0_0_1_00); pa(5'b0_0_1_00); fr(1, ACT_NONE, 0);
        idle_cycles(5);

        // ---------------- final report ----------------
        checks++;
        if (exp_q_a.size() != 0) begin
            errors++;
            $display("FAIL drain_a: got %0d pending events expected 0", exp_q_a.size());
        end
        checks++;
        if (exp_q_b.size() != 0) begin
            errors++;
            $display("FAIL drain_b: got %0d pending events expected 0", exp_q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prompt_sequencer.md
Name: prompt_sequencer

Overview:
- Frame-synchronous scheduler for the on-screen prompt sprite overlays.
- Each overlay controller takes an `en` input and draws its ROM sprite over the background.
- This block drives those enables so that prompts 0..N_PROMPTS-1 are shown one at a time, for fixed frame counts, with blank gaps and optional blinking.
- Enables change only at end-of-frame, so a sprite is never torn mid-frame. Sits between game FSM (start/skip) and overlay controllers.

Parameters:
- N_PROMPTS, 4, number of prompt overlays sequenced (>=1).
- SHOW_FRAMES, 120, frames each prompt is displayed (>=1).
- GAP_FRAMES, 30, blank frames between prompts (>=1).
- BLINK_FRAMES, 0, half-period of blink in frames; 0 = steady (no blink).
- H_LAST, 799, last hCount value of a line.
- V_LAST, 524, last vCount value of a frame.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- hCount  input  10  horizontal pixel counter from VGA timing.
- vCount  input  10  vertical line counter from VGA timing.
- start  input  1  begin sequence; sampled only in IDLE.
- skip  input  1  request early advance from current SHOW prompt.
- en_out  output  N_PROMPTS  one-hot/zero overlay enables; bit i drives overlay i.
- prompt_idx  output  clog2(N_PROMPTS) (min 1)  index of current prompt.
- busy  output  1  high in ARM, SHOW, GAP.
- done  output  1  one-cycle pulse when sequence completes.
- frame_tick  output  1  one-cycle pulse per frame boundary.

Behaviour:
- eof = (hCount==H_LAST && vCount==V_LAST), combinational. eof_q registers eof.
- Internal tick = eof & ~eof_q. This is one cycle per frame even when the counters hold for several clk cycles per pixel.
- frame_tick output = tick registered (1 cycle latency). It is aligned with en_out updates.
- Reset (synchronous): state=IDLE, prompt_idx=0, frame cnt=0, blink phase=0, eof_q=0, skip_pend=0. All outputs are 0.
- States:
  - IDLE: en_out=0. start=1 -> ARM (next edge). start is ignored in all other states.
  - ARM: wait for tick. On tick -> SHOW, idx=0, cnt=0, phase=0.
  - SHOW: en_out = (1<<idx) when phase==0, else 0.
    - On tick: if skip_pend or cnt==SHOW_FRAMES-1 -> GAP with cnt=0, skip_pend cleared. Else cnt+1.
    - Blink (BLINK_FRAMES>0): a separate blink counter toggles phase every BLINK_FRAMES ticks. The first frame is visible.
  - GAP: en_out=0. On tick: if cnt==GAP_FRAMES-1, then either idx==N_PROMPTS-1 -> DONE, or -> SHOW with idx+1, cnt=0, phase=0. Else cnt+1.
  - DONE: done=1 for exactly one cycle, en_out=0, busy=0 -> IDLE. prompt_idx holds last value until next start.
- State/en_out/prompt_idx are registered. They update on the clk edge where tick=1, so new enables are visible from the first pixel of the next frame.
- Transitions are driven by tick only. Only the IDLE->ARM and DONE->IDLE transitions are not tick-driven.
- skip:
  - A skip seen in SHOW sets skip_pend. It takes effect at the next tick.
  - skip in the same cycle as tick in SHOW takes effect on that tick.
  - skip outside SHOW is ignored and does not set skip_pend.
- Counters are sized clog2 of the relevant parameter + 1. They never wrap; compare-equal terminates.
- start and rst in the same cycle: rst wins.
- rst mid-sequence: returns to IDLE next edge, en_out=0 immediately after that edge, no done pulse.
- N_PROMPTS=1: one SHOW, one GAP, then DONE.
- Invariant: popcount(en_out) <= 1 at all times.

Test Plan:
- Bench parameters: H_LAST=9, V_LAST=4, N_PROMPTS=2, SHOW_FRAMES=3, GAP_FRAMES=1, BLINK_FRAMES=0. Counters advance every clk (frame = 50 clk).
- Basic sequence: pulse start in IDLE -> busy=1; en_out=2'b01 for 3 frames, 00 for 1 frame, 2'b10 for 3 frames, 00 for 1 frame. Then done pulses one cycle, busy=0. Each en_out change is coincident with a frame_tick.
- Slow pixel clock: counters advance every 4 clk (eof high 4 cycles) -> exactly one frame_tick per frame; same frame counts as the basic sequence.
- Skip: skip pulse mid-frame 1 of prompt 0 -> prompt 0 shown 1 frame only, then gap, then prompt 1 shown full 3 frames. skip during GAP has no effect.
- Blink (BLINK_FRAMES=1, SHOW_FRAMES=4): prompt 0 en pattern over frames = 1,0,1,0, then gap.
- Reset/ignore: start during SHOW ignored (sequence unchanged); rst asserted in prompt 1 SHOW -> next edge en_out=0, busy=0, prompt_idx=0, no done. A new start restarts at prompt 0.
